// File: rtl/mem_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Holds the FSM state encoding and the transaction-owner encoding.
`timescale 1ns/1ps
package mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-input alternating-priority picker; data wins unless it won last time.
// The last-grant register only moves when the pick is actually taken.
`timescale 1ns/1ps
module arb_rr2
   import mem_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   req_fetch,
   input  logic   req_data,
   input  logic   take,
   output owner_t pick
);

   owner_t last;

   always_comb begin
      // NOTE: default assignment first so every path drives pick and no latch is inferred.
      pick = OWN_I;
      if (req_data && !(req_fetch && last == OWN_D))
         pick = OWN_D;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n)
         last <= OWN_I;
      else if (take)
         last <= pick;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one memory port,
// one transaction outstanding, with a wait-cycle timeout that completes with err.
`timescale 1ns/1ps
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 255
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ack,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_wmask,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                m_valid,
   output logic                m_we,
   output logic [DATA_W/8-1:0] m_wmask,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ready,
   output logic                err
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(TIMEOUT - 1);

   state_t           state;
   owner_t           owner;
   owner_t           pick;
   logic [CNT_W-1:0] wait_cnt;
   logic             take;

   assign take = (state == IDLE) && (i_req || d_req);

   arb_rr2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_fetch (i_req),
      .req_data  (d_req),
      .take      (take),
      .pick      (pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= OWN_I;
         wait_cnt <= '0;
         m_valid  <= 1'b0;
         m_we     <= 1'b0;
         m_wmask  <= '0;
         m_addr   <= '0;
         m_wdata  <= '0;
         i_ack    <= 1'b0;
         d_ack    <= 1'b0;
         err      <= 1'b0;
         i_rdata  <= '0;
         d_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  owner    <= pick;
                  wait_cnt <= '0;
                  m_valid  <= 1'b1;
                  state    <= BUSY;
                  if (pick == OWN_D) begin
                     m_we    <= d_we;
                     m_wmask <= d_wmask;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                  end else begin
                     m_we    <= 1'b0;
                     m_wmask <= '0;
                     m_addr  <= i_addr;
                     m_wdata <= '0;
                  end
               end
            end
            BUSY: begin
               // A timed-out transaction completes like a normal one, but with err and zero data.
               if (m_ready || wait_cnt == WAIT_LIM) begin
                  m_valid <= 1'b0;
                  err     <= !m_ready;
                  state   <= DONE;
                  if (owner == OWN_D) begin
                     d_ack   <= 1'b1;
                     d_rdata <= m_ready ? m_rdata : '0;
                  end else begin
                     i_ack   <= 1'b1;
                     i_rdata <= m_ready ? m_rdata : '0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               i_ack <= 1'b0;
               d_ack <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-exact bench for mem_arbiter: a default instance plus a TIMEOUT=4
// instance sharing the same stimulus, the latter checked only in the timeout scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_wmask;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] m_rdata;
   logic        m_ready;

   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic        i_ack, d_ack, m_valid, m_we, err;
   logic [3:0]  m_wmask;

   logic [31:0] t_i_rdata, t_d_rdata, t_m_addr, t_m_wdata;
   logic        t_i_ack, t_d_ack, t_m_valid, t_m_we, t_err;
   logic [3:0]  t_m_wmask;

   int vectors;
   int miscompares;
   int both_ack;

   mem_arbiter u_dut (
      .clk (clk), .rst_n (rst_n),
      .i_req (i_req), .i_addr (i_addr), .i_rdata (i_rdata), .i_ack (i_ack),
      .d_req (d_req), .d_we (d_we), .d_wmask (d_wmask), .d_addr (d_addr),
      .d_wdata (d_wdata), .d_rdata (d_rdata), .d_ack (d_ack),
      .m_valid (m_valid), .m_we (m_we), .m_wmask (m_wmask), .m_addr (m_addr),
      .m_wdata (m_wdata), .m_rdata (m_rdata), .m_ready (m_ready), .err (err)
   );

   mem_arbiter #(.TIMEOUT(4)) u_dut_t4 (
      .clk (clk), .rst_n (rst_n),
      .i_req (i_req), .i_addr (i_addr), .i_rdata (t_i_rdata), .i_ack (t_i_ack),
      .d_req (d_req), .d_we (d_we), .d_wmask (d_wmask), .d_addr (d_addr),
      .d_wdata (d_wdata), .d_rdata (t_d_rdata), .d_ack (t_d_ack),
      .m_valid (t_m_valid), .m_we (t_m_we), .m_wmask (t_m_wmask), .m_addr (t_m_addr),
      .m_wdata (t_m_wdata), .m_rdata (m_rdata), .m_ready (m_ready), .err (t_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (i_ack && d_ack)
         both_ack++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_req   = 1'b0;
      i_addr  = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_wmask = '0;
      d_addr  = '0;
      d_wdata = '0;
      m_rdata = '0;
      m_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      both_ack    = 0;
      rst_n       = 1'b1;
      clear_inputs();

      // Reset state
      do_reset();
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_acks",    {i_ack, d_ack, err}, 3'b000);
      check("rst_rdata",   {i_rdata, d_rdata}, 64'h0);

      // Single zero-wait fetch
      i_req  = 1'b1;
      i_addr = 32'h100;
      check("f_c0_mvalid", m_valid, 1'b0);
      tick();
      check("f_c1_cmd", {m_valid, m_we, m_wmask, m_addr, m_wdata}, {1'b1, 1'b0, 4'h0, 32'h100, 32'h0});
      check("f_c1_ack", i_ack, 1'b0);
      m_ready = 1'b1;
      m_rdata = 32'h0000_0013;
      tick();
      m_ready = 1'b0;
      check("f_c2_ack",   {i_ack, d_ack, err, m_valid}, 4'b1000);
      check("f_c2_rdata", i_rdata, 32'h0000_0013);
      i_req = 1'b0;
      tick();
      check("f_c3_ack", i_ack, 1'b0);
      tick();
      check("f_c4_idle", m_valid, 1'b0);

      // Contention: data, then fetch, then data again, every 3 cycles
      do_reset();
      i_req  = 1'b1;
      i_addr = 32'h104;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h2000;
      tick();
      check("c_c1_cmd", {m_valid, m_we, m_addr}, {1'b1, 1'b0, 32'h2000});
      m_ready = 1'b1;
      m_rdata = 32'hAAAA_0001;
      tick();
      m_ready = 1'b0;
      check("c_c2_ack",   {i_ack, d_ack}, 2'b01);
      check("c_c2_rdata", d_rdata, 32'hAAAA_0001);
      tick();
      check("c_c3_mvalid", m_valid, 1'b0);
      tick();
      check("c_c4_cmd", {m_valid, m_we, m_wmask, m_addr, m_wdata}, {1'b1, 1'b0, 4'h0, 32'h104, 32'h0});
      m_ready = 1'b1;
      m_rdata = 32'hBBBB_0002;
      tick();
      m_ready = 1'b0;
      check("c_c5_ack",    {i_ack, d_ack}, 2'b10);
      check("c_c5_rdata",  {i_rdata, d_rdata}, {32'hBBBB_0002, 32'hAAAA_0001});
      i_req = 1'b0;
      tick();
      tick();
      check("c_c7_cmd", {m_valid, m_addr}, {1'b1, 32'h2000});
      m_ready = 1'b1;
      m_rdata = 32'hCCCC_0003;
      tick();
      m_ready = 1'b0;
      check("c_c8_ack",   {i_ack, d_ack}, 2'b01);
      check("c_c8_rdata", {i_rdata, d_rdata}, {32'hBBBB_0002, 32'hCCCC_0003});
      d_req = 1'b0;
      tick();

      // Store with five wait cycles
      do_reset();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_wmask = 4'b0011;
      d_addr  = 32'h2004;
      d_wdata = 32'hDEAD_BEEF;
      tick();
      for (int k = 1; k <= 6; k++) begin
         check("st_cmd",  {m_valid, m_we, m_wmask, m_addr, m_wdata},
                          {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF});
         check("st_wait", {i_ack, d_ack, err}, 3'b000);
         if (k == 6)
            m_ready = 1'b1;
         tick();
      end
      m_ready = 1'b0;
      check("st_ack", {i_ack, d_ack, err, m_valid}, 4'b0100);
      d_req = 1'b0;
      tick();
      check("st_after", {i_ack, d_ack, m_valid}, 3'b000);

      // Timeout on the TIMEOUT=4 instance, after a good load leaves nonzero rdata
      do_reset();
      d_req  = 1'b1;
      d_addr = 32'h3000;
      tick();
      check("to_c1_mvalid", t_m_valid, 1'b1);
      m_ready = 1'b1;
      m_rdata = 32'h55AA_55AA;
      tick();
      m_ready = 1'b0;
      check("to_c2_ack", {t_d_ack, t_err, t_d_rdata}, {1'b1, 1'b0, 32'h55AA_55AA});
      tick();
      check("to_c3_mvalid", t_m_valid, 1'b0);
      tick();
      for (int k = 4; k <= 7; k++) begin
         check("to_busy", {t_m_valid, t_d_ack, t_err}, 3'b100);
         tick();
      end
      check("to_c8_ack", {t_m_valid, t_i_ack, t_d_ack, t_err, t_d_rdata}, {4'b0011, 32'h0});
      d_req = 1'b0;
      tick();
      check("to_c9_clear", {t_d_ack, t_err}, 2'b00);

      // Asynchronous reset during BUSY, then normal grants
      do_reset();
      d_req  = 1'b1;
      d_addr = 32'h4000;
      tick();
      check("ar_busy", m_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_async", {m_valid, d_ack}, 2'b00);
      d_req = 1'b0;
      tick();
      check("ar_noack", {m_valid, i_ack, d_ack}, 3'b000);
      rst_n  = 1'b1;
      i_req  = 1'b1;
      i_addr = 32'h108;
      d_req  = 1'b1;
      tick();
      check("ar_regrant", {m_valid, m_we, m_addr}, {1'b1, 1'b0, 32'h4000});
      m_ready = 1'b1;
      m_rdata = 32'h1234_5678;
      tick();
      m_ready = 1'b0;
      check("ar_dack", {i_ack, d_ack, d_rdata}, {2'b01, 32'h1234_5678});
      d_req = 1'b0;
      tick();
      tick();
      check("ar_fetch", {m_valid, m_addr}, {1'b1, 32'h108});
      m_ready = 1'b1;
      m_rdata = 32'h0000_0093;
      tick();
      m_ready = 1'b0;
      check("ar_iack", {i_ack, d_ack, i_rdata, d_rdata}, {2'b10, 32'h93, 32'h1234_5678});
      i_req = 1'b0;
      tick();

      // Stray m_ready while idle
      tick();
      m_ready = 1'b1;
      m_rdata = 32'hFFFF_FFFF;
      tick();
      m_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("idle_ready", {m_valid, i_ack, d_ack, err, i_rdata, d_rdata},
                             {4'b0000, 32'h93, 32'h1234_5678});
         tick();
      end

      check("no_dual_ack", both_ack, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
